// File: rtl/core_pkg.sv
// Shared core types and constants used by the fetch stage and its buffer.
package core_pkg;

    localparam int          OPCODE_W         = 7;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One buffered fetch result: the word and the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Major opcode field as seen by the control decoder.
    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [31:0] instr);
        return instr[OPCODE_W-1:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush, occupancy count and
// asynchronous active-high reset. Flush wins over push/pop in the same cycle.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Accept a push when there is room or the head leaves in the same cycle.
    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head    = mem[rd_ptr];
    end

    // Pointer and occupancy update; flush empties the buffer in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order word fetches, buffers
// returned words and hands {pc, instr, opcode} to decode. Redirects from
// execute flush the buffer and drop every response still in flight.
// Optional build macro FETCH_BYPASS_EN: a kept response arriving while the
// buffer is empty is presented to decode in the same cycle.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// valid never waits on ready; the fetch request (valid, addr) stays put while
// it is not accepted unless a redirect replaces it. Memory responses carry no
// ready and must always be taken.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [31:0]         imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [31:0]         if_pc,
    output logic [31:0]         if_instr,
    output logic [OPCODE_W-1:0] if_opcode
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_count;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic [31:0]   redirect_target;
    logic          req_fire;
    logic          rsp_keep;
    logic          bypass_hit;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  fifo_head;
    fetch_entry_t  rsp_entry;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (rsp_entry),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Response filtering, credit check and decode-side presentation.
    always_comb begin
        redirect_target = {redirect_pc[31:2], 2'b00};
        // A response in the redirect cycle belongs to the old path too.
        rsp_keep  = imem_rsp_valid && (drop_count == '0) && !redirect_valid;
        rsp_entry = '{pc: rsp_pc, instr: imem_rsp_data};
`ifdef FETCH_BYPASS_EN
        bypass_hit = rsp_keep && fifo_empty;
`else
        bypass_hit = 1'b0;
`endif
        if_valid  = !rst && !redirect_valid && (!fifo_empty || bypass_hit);
        fifo_pop  = if_valid && if_ready && !fifo_empty;
        // Credits already reserve the slot; the full guard only protects
        // the buffer from a memory that returns more words than requested.
        fifo_push = rsp_keep && !(bypass_hit && if_ready) && (!fifo_full || fifo_pop);

        // Every in-flight request and buffered word holds one buffer slot.
        credit_used    = {1'b0, outstanding} + {1'b0, fifo_count} - (CW+1)'(fifo_pop);
        imem_req_valid = !rst && !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));
        imem_req_addr  = pc;
        req_fire       = imem_req_valid && imem_req_ready;

        if (!if_valid) begin
            if_pc    = '0;
            if_instr = NOP_INSTR;
        end else if (!fifo_empty) begin
            if_pc    = fifo_head.pc;
            if_instr = fifo_head.instr;
        end else begin
            if_pc    = rsp_entry.pc;
            if_instr = rsp_entry.instr;
        end
        if_opcode = opcode_of(if_instr);
    end

    // PC, response-PC tag, in-flight count and stale-response drop count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_count  <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                pc     <= redirect_target;
                rsp_pc <= redirect_target;
                // Every response still owed is stale now, including ones that
                // were already marked for dropping, so the count is reloaded
                // from the in-flight total rather than accumulated.
                drop_count <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) pc <= pc + 32'd4;
                // Kept responses arrive in request order from a sequential
                // stream, so their PC is a running tag rather than a queue.
                if (rsp_keep) rsp_pc <= rsp_pc + 32'd4;
                if (imem_rsp_valid && (drop_count != '0)) drop_count <= drop_count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural memory with per-request latency, a
// program-order reference stream and an expected-PC queue checked on every
// decode pop. Builds with or without FETCH_BYPASS_EN.
module tb_fetch_unit;
    import core_pkg::*;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic                clk;
    logic                rst;
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [31:0]         imem_req_addr;
    logic                imem_rsp_valid;
    logic [31:0]         imem_rsp_data;
    logic                redirect_valid;
    logic [31:0]         redirect_pc;
    logic                if_valid;
    logic                if_ready;
    logic [31:0]         if_pc;
    logic [31:0]         if_instr;
    logic [OPCODE_W-1:0] if_opcode;

    fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_opcode      (if_opcode)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       pending[$];
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    int total, bad, cyc, last_due, pops;
    int lat_mode;      // 0: random 1..3 cycles, otherwise fixed latency
    int req_rdy_mode;  // 0: always ready, 1: random, 2: never ready
    int if_rdy_mode;   // 0: always ready, 1: held low, 2: random

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0135_7913;
    endfunction

    task automatic check(input string name, input logic ok,
                         input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory + ready drivers (posedge + 1) ----------------
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (rst) begin
            pending.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else begin
            if (imem_rsp_valid && pending.size() > 0) pending.delete(0);
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            if (pending.size() > 0 && pending[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pending[0].addr);
            end
        end
        case (req_rdy_mode)
            0:       imem_req_ready = 1'b1;
            1:       imem_req_ready = ($urandom_range(0, 1) == 1);
            default: imem_req_ready = 1'b0;
        endcase
        case (if_rdy_mode)
            0:       if_ready = 1'b1;
            1:       if_ready = 1'b0;
            default: if_ready = ($urandom_range(0, 1) == 1);
        endcase
    end

    // ---------------- request acceptance: reference stream + expected queue ----------------
    always @(negedge clk) begin : req_side
        int lat;
        int due;
        if (rst) begin
            exp_q.delete();
            model_pc = RPC;
            last_due = 0;
        end else if (redirect_valid) begin
            check("no_req_in_redirect", !imem_req_valid, 32'(imem_req_valid), 32'd0);
            model_pc = redirect_pc & 32'hFFFF_FFFC;
            exp_q.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr == model_pc, imem_req_addr, model_pc);
            lat = (lat_mode == 0) ? $urandom_range(1, 3) : lat_mode;
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pending.push_back('{imem_req_addr, due});
            exp_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
            check("credit_bound", pending.size() <= DEPTH, 32'(pending.size()), 32'(DEPTH));
        end
    end

    // ---------------- decode-side monitor ----------------
    always @(negedge clk) begin : mon
        logic [31:0] e;
        if (!rst) begin
            if (redirect_valid)
                check("if_valid_in_redirect", !if_valid, 32'(if_valid), 32'd0);
            if (if_valid) begin
                check("opcode_field", if_opcode == if_instr[6:0], 32'(if_opcode), 32'(if_instr[6:0]));
                if (if_ready) begin
                    if (exp_q.size() == 0) begin
                        check("pop_without_request", 1'b0, if_pc, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("if_pc", if_pc == e, if_pc, e);
                        check("if_instr", if_instr == mem_word(e), if_instr, mem_word(e));
                        pops++;
                    end
                end
            end else begin
                check("empty_outputs",
                      if_instr == NOP_INSTR && if_pc == 32'd0 && if_opcode == 7'b0010011,
                      if_instr ^ if_pc ^ 32'(if_opcode) ^ 32'(7'b0010011), NOP_INSTR);
            end
        end
    end

    // ---------------- directed + random sequence ----------------
    task automatic pulse_redirect(input logic [31:0] target);
        redirect_pc    = target;
        redirect_valid = 1'b1;
        @(posedge clk); #2;
        redirect_valid = 1'b0;
    endtask

    task automatic wait_pop(input int budget, output logic seen, output logic [31:0] pc_seen);
        seen    = 1'b0;
        pc_seen = '0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (if_valid && if_ready) begin
                seen    = 1'b1;
                pc_seen = if_pc;
            end
        end
    endtask

    initial begin : seq
        logic        seen;
        logic [31:0] pcs;
        int          n;
        int          p0;
        total = 0; bad = 0; cyc = 0; pops = 0; last_due = 0;
        lat_mode = 1; req_rdy_mode = 0; if_rdy_mode = 0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; if_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        model_pc = RPC;

        // Reset state, with a redirect that must be ignored during reset.
        repeat (3) @(posedge clk);
        #2 redirect_valid = 1'b1; redirect_pc = 32'h0000_0500;
        @(negedge clk);
        check("rst_req_valid", !imem_req_valid, 32'(imem_req_valid), 32'd0);
        check("rst_if_valid", !if_valid, 32'(if_valid), 32'd0);
        check("rst_if_instr", if_instr == NOP_INSTR, if_instr, NOP_INSTR);
        check("rst_if_pc", if_pc == 32'd0, if_pc, 32'd0);
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        rst = 1'b0;

        // Startup latency with 1-cycle memory.
        @(negedge clk);
        check("c0_req_valid", imem_req_valid, 32'(imem_req_valid), 32'd1);
        check("c0_req_addr", imem_req_addr == RPC, imem_req_addr, RPC);
        check("c0_if_valid", !if_valid, 32'(if_valid), 32'd0);
        @(negedge clk);
        check("c1_req_addr", imem_req_addr == RPC + 32'd4, imem_req_addr, RPC + 32'd4);
`ifdef FETCH_BYPASS_EN
        check("c1_if_valid", if_valid && if_pc == RPC, if_pc, RPC);
`else
        check("c1_if_valid", !if_valid, 32'(if_valid), 32'd0);
`endif
        @(negedge clk);
        check("c2_req_addr", imem_req_addr == RPC + 32'd8, imem_req_addr, RPC + 32'd8);
`ifdef FETCH_BYPASS_EN
        check("c2_if_pc", if_valid && if_pc == RPC + 32'd4, if_pc, RPC + 32'd4);
`else
        check("c2_if_pc", if_valid && if_pc == RPC, if_pc, RPC);
`endif

        // Sustained throughput.
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_valid && if_ready) n++;
        end
        check("throughput", n == 20, 32'(n), 32'd20);

        // Decode stalled for 10 cycles.
        @(posedge clk); #2 if_rdy_mode = 1;
        @(posedge clk);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) n++;
        end
        check("stall_req_count", n <= DEPTH, 32'(n), 32'(DEPTH));
        check("stall_req_valid_low", !imem_req_valid, 32'(imem_req_valid), 32'd0);
        check("stall_if_valid_high", if_valid, 32'(if_valid), 32'd1);
        @(posedge clk); #2 if_rdy_mode = 0;
        repeat (8) @(posedge clk);

        // Redirect with requests outstanding on 3-cycle memory.
        #2 lat_mode = 3;
        n = 0;
        while (pending.size() < 2 && n < 30) begin
            @(posedge clk); #2;
            n++;
        end
        check("two_outstanding_reached", pending.size() >= 2, 32'(pending.size()), 32'd2);
        pulse_redirect(32'h0000_0100);
        wait_pop(40, seen, pcs);
        check("redirect_first_pc", seen && pcs == 32'h0000_0100, pcs, 32'h0000_0100);
        @(posedge clk); #2 req_rdy_mode = 2;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("drained_credit_free", imem_req_valid && !if_valid, 32'({imem_req_valid, if_valid}), 32'b10);
        @(posedge clk); #2 req_rdy_mode = 0; lat_mode = 1;
        repeat (6) @(posedge clk);

        // Redirect in the same cycle as a response, misaligned target.
        #2;
        n = 0;
        while (!imem_rsp_valid && n < 30) begin
            @(posedge clk); #2;
            n++;
        end
        check("rsp_present_for_redirect", imem_rsp_valid, 32'(imem_rsp_valid), 32'd1);
        pulse_redirect(32'h0000_0203);
        @(negedge clk);
        check("aligned_req", imem_req_valid && imem_req_addr == 32'h0000_0200, imem_req_addr, 32'h0000_0200);
        wait_pop(20, seen, pcs);
        check("aligned_first_pc", seen && pcs == 32'h0000_0200, pcs, 32'h0000_0200);

        // PC wrap at the top of the address space.
        @(posedge clk); #2;
        pulse_redirect(32'hFFFF_FFF4);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_valid && if_ready && if_pc == 32'd0) seen = 1'b1;
        end
        check("pc_wrap_to_zero", seen, 32'(seen), 32'd1);

        // Random handshakes, latencies and redirects.
        @(posedge clk); #2;
        lat_mode = 0; req_rdy_mode = 1; if_rdy_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #2;
            if (redirect_valid) begin
                redirect_valid = 1'b0;
            end else if ($urandom_range(0, 29) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else
                    redirect_pc = $urandom & 32'h0000_FFFF;
                redirect_valid = 1'b1;
            end
        end
        redirect_valid = 1'b0;

        // Drain with everything ready: the stream must keep flowing.
        lat_mode = 1; req_rdy_mode = 0; if_rdy_mode = 0;
        repeat (4) @(posedge clk);
        p0 = pops;
        repeat (20) @(posedge clk);
        check("drain_progress", (pops - p0) >= 15, 32'(pops - p0), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule
